// File: rtl/regfile_writer_pkg.sv
// Shared definitions for the MIPS register-file write path.
// Used by the register file and by regfile_writer.
package regfile_writer_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_AW    = 5;

    localparam logic [DEF_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [DEF_AW-1:0]    addr;
        logic [DEF_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/regfile_writer_if.sv
// Write-request handshake between the pipeline (master)
// and regfile_writer (slave).
interface regfile_writer_if
    import regfile_writer_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int WIDTH = DEF_WIDTH
);

    logic             InValid;
    logic             InReady;
    logic [AW-1:0]    InRegister;
    logic [WIDTH-1:0] InData;

    modport master (
        output InValid,
        output InRegister,
        output InData,
        input  InReady
    );

    modport slave (
        input  InValid,
        input  InRegister,
        input  InData,
        output InReady
    );

endinterface

// File: rtl/regfile_writer_wb_queue.sv
// Circular write-back buffer with head/tail pointers, occupancy,
// and an age-ordered view of all slots (index 0 is the head).
module wb_queue #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 32,
    parameter int  AW    = 5,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [AW-1:0]          push_addr_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [CW-1:0]          count_o,
    output logic [AW-1:0]          head_addr_o,
    output logic [WIDTH-1:0]       head_data_o,
    output logic [DEPTH-1:0]       valid_o,
    output logic [DEPTH*AW-1:0]    addr_o,
    output logic [DEPTH*WIDTH-1:0] data_o
);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] slot;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) tail_d = tail_q + 1'b1;
        if (pop_i)  head_d = head_q + 1'b1;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy gates every use.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    always_comb begin
        slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot                     = head_q + PW'(i);
            valid_o[i]               = CW'(i) < count_q;
            addr_o[i*AW +: AW]       = addr_q[slot];
            data_o[i*WIDTH +: WIDTH] = data_q[slot];
        end
    end

    assign count_o     = count_q;
    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];

endmodule

// File: rtl/regfile_writer.sv
// Buffered write-side initiator for the 32x32 MIPS register file,
// with queued-value forwarding for two read addresses.
module regfile_writer
    import regfile_writer_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  AW    = DEF_AW,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    regfile_writer_if.slave  req,
    input  logic             Hold,
    output logic [AW-1:0]    WriteRegister,
    output logic [WIDTH-1:0] WriteData,
    output logic             RegWrite,
    input  logic [AW-1:0]    QueryReg1,
    input  logic [AW-1:0]    QueryReg2,
    output logic             Pending1,
    output logic             Pending2,
    output logic [WIDTH-1:0] Fwd1,
    output logic [WIDTH-1:0] Fwd2,
    output logic [CW-1:0]    Count,
    output logic             Empty
);

    logic [CW-1:0]          count;
    logic [AW-1:0]          head_addr;
    logic [WIDTH-1:0]       head_data;
    logic [DEPTH-1:0]       valid;
    logic [DEPTH*AW-1:0]    addrs;
    logic [DEPTH*WIDTH-1:0] datas;
    logic                   push;
    logic                   pop;
    logic                   empty;

    assign empty       = (count == '0);
    assign req.InReady = (count < CW'(DEPTH));
    assign push        = req.InValid && req.InReady
                       && (req.InRegister != AW'(ZERO_REG));
    assign pop         = !empty && !Hold;

    wb_queue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_queue (
        .clk         (Clk),
        .rst         (Reset),
        .push_i      (push),
        .push_addr_i (req.InRegister),
        .push_data_i (req.InData),
        .pop_i       (pop),
        .count_o     (count),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .valid_o     (valid),
        .addr_o      (addrs),
        .data_o      (datas)
    );

    // Entries are scanned oldest first, so a later match is younger.
    function automatic logic [WIDTH:0] lookup(
        input logic [AW-1:0]          q,
        input logic [DEPTH-1:0]       v,
        input logic [DEPTH*AW-1:0]    a,
        input logic [DEPTH*WIDTH-1:0] d
    );
        logic [WIDTH:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q != AW'(ZERO_REG) && v[i] && a[i*AW +: AW] == q)
                r = {1'b1, d[i*WIDTH +: WIDTH]};
        end
        return r;
    endfunction

    assign {Pending1, Fwd1} = lookup(QueryReg1, valid, addrs, datas);
    assign {Pending2, Fwd2} = lookup(QueryReg2, valid, addrs, datas);

    assign RegWrite      = pop;
    assign WriteRegister = empty ? '0 : head_addr;
    assign WriteData     = empty ? '0 : head_data;
    assign Count         = count;
    assign Empty         = empty;

endmodule

// File: doc/regfile_writer.md
# regfile_writer

Buffered write-side initiator for the 32 x 32-bit MIPS register file. It accepts register write requests from the execute/memory pipeline over a valid/ready handshake and queues them in a small in-order FIFO. It drains one entry per cycle onto the register file's synchronous write port (WriteRegister, WriteData, RegWrite). It also reports, for two read addresses, whether a newer value is still queued, and supplies that value for forwarding.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- WIDTH, 32, data width
- AW, 5, register address width

Clock and reset are fixed:
- Clk  in  1  clock; all state changes on the positive edge
- Reset  in  1  asynchronous, active-high; clears all state immediately

Request side:
- InValid  in  1  write request present
- InReady  out  1  block can accept a request this cycle
- InRegister  in  AW  destination register address
- InData  in  WIDTH  value to write

Register file side:
- Hold  in  1  suppresses draining this cycle
- WriteRegister  out  AW  address driven to the register file
- WriteData  out  WIDTH  data driven to the register file
- RegWrite  out  1  register file write enable

Query and status:
- QueryReg1, QueryReg2  in  AW  read addresses being decoded
- Pending1, Pending2  out  1  a queued entry targets QueryRegN
- Fwd1, Fwd2  out  WIDTH  data of the youngest queued entry matching QueryRegN; 0 when PendingN=0
- Count  out  $clog2(DEPTH)+1  number of queued entries
- Empty  out  1  Count==0

## Operation
- **Accept:** a request is accepted when InValid && InReady. InReady = (Count < DEPTH). InReady depends only on registered state, never on the same-cycle drain.
- **Register 0:** an accepted request with InRegister==0 completes the handshake but is discarded. It is not enqueued and Count is unchanged.
- **Drain:** when !Empty, the outputs present the head entry:
  - RegWrite=1, WriteRegister=head address, WriteData=head data.
  - When Empty, all three outputs are 0.
- **Hold:** Hold=1 forces RegWrite=0, and the head is not popped. WriteRegister and WriteData still show the head entry.
- **Pop:** the head is popped on every edge where RegWrite=1. The register file captures the write on that same edge.
- **Push and pop together:** a push and a pop on the same edge leave Count unchanged. Pointers wrap modulo DEPTH.
- **Pending lookup:** PendingN=1 iff QueryRegN!=0 and some valid entry has a matching address.
  - FwdN is the data of the youngest matching entry, by insertion order.
  - The head entry counts as a valid entry, including the cycle in which it is being written.
  - Same-cycle incoming requests are not considered.
  - Lookup is combinational from state and QueryRegN.
- **Ordering:** entries drain strictly in acceptance order. Multiple queued writes to the same register are all performed, in order.
- **Reset:** Reset clears head, tail and Count immediately, regardless of Clk. In-flight entries are lost.

Reset values:
- Count=0, Empty=1, InReady=1.
- RegWrite=0, WriteRegister=0, WriteData=0.
- Pending1=Pending2=0, Fwd1=Fwd2=0.

## Timing
- **Latency:** a request accepted at edge N, into an empty queue with Hold=0, drives RegWrite=1 during cycle N..N+1. It is written into the register file at edge N+1.
- **Throughput:** one accept and one drain per cycle, sustained.
- **Full queue:** when full, InReady=0 for that whole cycle, even if a pop occurs on the same edge. InReady returns to 1 in the cycle after the pop.
- **Pending clearing:** PendingN for an entry clears in the cycle after that entry's write edge. From then on the register file holds the value, so forwarding is no longer needed.
- **Reset deassertion:** Reset may deassert asynchronously. The first accept is possible at the first edge after deassertion.

## Structure
- **Shared package:** holds the default DEPTH, WIDTH and AW, the ZERO_REG=0 constant, and an entry typedef {addr[AW-1:0], data[WIDTH-1:0]}. The register file and this block both use the package.
- **Sub-module:** one sub-module, wb_queue, containing:
  - the circular buffer with head/tail pointers and Count;
  - push and pop ports;
  - a flattened view of all valid entries.
- **Top level:** regfile_writer adds the handshake, the register-0 filter, Hold gating, and the two youngest-match lookup trees.

## Test plan
- Reset, then accept (r5, 0xDEADBEEF) with Hold=0 → RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF in the next cycle; Count returns to 0 after the write edge.
- Hold=1 and push r1..r4 (data 1..4) → InReady=0 at Count=4 and the 5th request stalls. Then release Hold → writes r1, r2, r3, r4 on consecutive edges and InReady rises the cycle after the first pop.
- Push (r0, 0x1234) → handshake completes, Count stays 0, RegWrite stays 0, and Pending1=0 with QueryReg1=0.
- Hold=1, push (r7, 0xA) then (r7, 0xB), QueryReg1=7 → Pending1=1, Fwd1=0xB. Release Hold → r7 is written 0xA then 0xB; Pending1 clears after the second write.
- Continuous push and drain for 3*DEPTH cycles with random Hold → writes exactly match acceptance order and pointers wrap without loss.
- Assert Reset mid-burst with Count=3 → outputs go to reset values immediately, no further RegWrite, and InReady=1.
